// File: rtl/vga_timing_gen_pkg.sv
// Shared types, mode constant sets and helpers for the VGA timing generator.
// Timing parameters of the supported display modes live here so every top-level can pick one.
package vga_timing_gen_pkg;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_bits_t;

    // 640x480@60, 25.175 MHz pixel clock, active-low sync
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;
    localparam bit VGA640_POL      = 1'b0;

    // 800x600@72, 50 MHz pixel clock, active-high sync
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FRONT  = 56;
    localparam int SVGA800_H_SYNC   = 120;
    localparam int SVGA800_H_BACK   = 64;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FRONT  = 37;
    localparam int SVGA800_V_SYNC   = 6;
    localparam int SVGA800_V_BACK   = 23;
    localparam bit SVGA800_POL      = 1'b1;

    // Map an "inside the sync window" flag onto the pin level for the given polarity.
    function automatic logic sync_level(input logic active, input bit pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// DEPTH-stage clock-enabled shift register with a synchronous reset value.
// DEPTH = 0 degenerates into a wire so callers can keep a single code path.
module vga_timing_gen_sync_delay_line #(
    parameter int              WIDTH     = 1,
    parameter int              DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, srst, ce};
            assign dout        = din;
        end else begin : g_pipe
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] q_reg;
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) begin
                        if (srst) begin
                            q_reg <= RESET_VAL;
                        end else if (ce) begin
                            q_reg <= din;
                        end
                    end
                end else begin : g_tail
                    always_ff @(posedge clk) begin
                        if (srst) begin
                            q_reg <= RESET_VAL;
                        end else if (ce) begin
                            q_reg <= g_stage[gi-1].q_reg;
                        end
                    end
                end
            end
            assign dout = g_stage[DEPTH-1].q_reg;
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: pixel tick, x/y counters, sync, blanking and strobes.
// Sync and video_on are registered from next-state counters so they always match pixel_x/pixel_y.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FRONT  = VGA640_H_FRONT,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BACK   = VGA640_H_BACK,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FRONT  = VGA640_V_FRONT,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BACK   = VGA640_V_BACK,
    parameter int CLK_DIV  = 2,
    parameter bit H_POL    = VGA640_POL,
    parameter bit V_POL    = VGA640_POL,
    parameter int PIPE     = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic p_tick,
    output logic [$clog2(H_ACTIVE+H_FRONT+H_SYNC+H_BACK)-1:0] pixel_x,
    output logic [$clog2(V_ACTIVE+V_FRONT+V_SYNC+V_BACK)-1:0] pixel_y,
    output logic video_on,
    output logic video_on_d,
    output logic hsync,
    output logic vsync,
    output logic line_start,
    output logic frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACTIVE = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FRONT);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACTIVE = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FRONT);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [2:0]    DLY_RESET = {~H_POL, ~V_POL, 1'b0};

    generate
        if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 || V_FRONT < 1 || V_SYNC < 1 ||
            V_BACK < 1 || CLK_DIV < 1 || PIPE < 0 || PIPE > 15) begin : g_bad_params
            $error("vga_timing_gen: porch/sync widths and CLK_DIV must be >= 1, PIPE in 0..15");
        end
    endgenerate

    logic [DW-1:0] div_reg;
    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;
    sync_bits_t    raw_reg, raw_next, dly_out;

    // Reset gating matters for CLK_DIV = 1, where div_reg sits at its last value during reset.
    assign p_tick = en && !reset && (div_reg == DIV_LAST);

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (p_tick) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                y_next = (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
            end else begin
                x_next = x_reg + XW'(1);
            end
        end
    end

    always_comb begin
        raw_next.hsync    = sync_level((x_next >= HS_START) && (x_next <= HS_END), H_POL);
        raw_next.vsync    = sync_level((y_next >= VS_START) && (y_next <= VS_END), V_POL);
        raw_next.video_on = (x_next < X_ACTIVE) && (y_next < Y_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg          <= '0;
            x_reg            <= '0;
            y_reg            <= '0;
            raw_reg.hsync    <= ~H_POL;
            raw_reg.vsync    <= ~V_POL;
            raw_reg.video_on <= 1'b1;
        end else begin
            if (en) begin
                div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + DW'(1);
            end
            x_reg   <= x_next;
            y_reg   <= y_next;
            raw_reg <= raw_next;
        end
    end

    vga_timing_gen_sync_delay_line #(
        .WIDTH     ($bits(sync_bits_t)),
        .DEPTH     (PIPE),
        .RESET_VAL (DLY_RESET)
    ) u_sync_delay (
        .clk  (clk),
        .srst (reset),
        .ce   (p_tick),
        .din  (raw_reg),
        .dout (dly_out)
    );

    assign pixel_x     = x_reg;
    assign pixel_y     = y_reg;
    assign video_on    = raw_reg.video_on;
    assign video_on_d  = dly_out.video_on;
    assign hsync       = dly_out.hsync;
    assign vsync       = dly_out.vsync;
    assign line_start  = p_tick && (x_reg == '0);
    assign frame_start = p_tick && (x_reg == '0) && (y_reg == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small mode (CLK_DIV 2, PIPE 2) and a 640-wide mode (CLK_DIV 1, PIPE 0),
// both compared every clk against a tick-count model of the raster.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2, HT = HA + HF + HS + HB;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
    localparam int CD = 2, PP = 2;
    localparam int BHA = 640, BHF = 16, BHS = 96, BHB = 48, BHT = BHA + BHF + BHS + BHB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a = 1'b1, en_a = 1'b0;
    logic       p_tick_a, video_on_a, video_on_d_a, hsync_a, vsync_a, line_start_a, frame_start_a;
    logic [3:0] pixel_x_a;
    logic [2:0] pixel_y_a;

    logic       reset_b = 1'b1, en_b = 1'b1;
    logic       p_tick_b, video_on_b, video_on_d_b, hsync_b, vsync_b, line_start_b, frame_start_b;
    logic [9:0] pixel_x_b;
    logic [2:0] pixel_y_b;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(CD), .H_POL(1'b0), .V_POL(1'b0), .PIPE(PP)
    ) dut_a (
        .clk(clk), .reset(reset_a), .en(en_a), .p_tick(p_tick_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .video_on(video_on_a),
        .video_on_d(video_on_d_a), .hsync(hsync_a), .vsync(vsync_a),
        .line_start(line_start_a), .frame_start(frame_start_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(1), .H_POL(1'b0), .V_POL(1'b0), .PIPE(0)
    ) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .p_tick(p_tick_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .video_on(video_on_b),
        .video_on_d(video_on_d_b), .hsync(hsync_b), .vsync(vsync_b),
        .line_start(line_start_b), .frame_start(frame_start_b)
    );

    int assert_cnt = 0;
    int fail_cnt   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Active-low sync: low while pos is inside [act+front, act+front+width-1].
    function automatic bit sync_level(input int pos, input int act, input int front, input int width);
        return !((pos >= act + front) && (pos < act + front + width));
    endfunction

    // Model state: n_* = enabled clks since the last reset; the raster follows from plain division.
    int n_a = 0, n_b = 0;
    bit known_a = 0, known_b = 0;

    bit meas_on = 0;
    int meas_cyc = 0, first_tick = -1, last_ls = -1, last_fs = -1, von_cnt = 0, vod_cnt = 0;
    int last_fs_b = -1, cyc_b = 0;

    task automatic check_a();
        int  k, x, y, j, xj, yj;
        bit  pt, hs, vs, vod;
        k  = n_a / CD;
        x  = k % HT;
        y  = (k / HT) % VT;
        pt = en_a && !reset_a && ((n_a % CD) == CD - 1);
        if (k >= PP) begin
            j   = k - PP;
            xj  = j % HT;
            yj  = (j / HT) % VT;
            hs  = sync_level(xj, HA, HF, HS);
            vs  = sync_level(yj, VA, VF, VS);
            vod = (xj < HA) && (yj < VA);
        end else begin
            hs = 1; vs = 1; vod = 0;
        end
        check_val("a_p_tick", p_tick_a, pt);
        check_val("a_pixel_x", pixel_x_a, x);
        check_val("a_pixel_y", pixel_y_a, y);
        check_val("a_video_on", video_on_a, (x < HA) && (y < VA));
        check_val("a_video_on_d", video_on_d_a, vod);
        check_val("a_hsync", hsync_a, hs);
        check_val("a_vsync", vsync_a, vs);
        check_val("a_line_start", line_start_a, pt && (x == 0));
        check_val("a_frame_start", frame_start_a, pt && (x == 0) && (y == 0));
    endtask

    task automatic measure_a();
        meas_cyc++;
        if (p_tick_a && first_tick < 0) first_tick = meas_cyc;
        if (line_start_a) begin
            if (last_ls >= 0) check_val("line_period", meas_cyc - last_ls, HT * CD);
            last_ls = meas_cyc;
        end
        if (frame_start_a) begin
            if (last_fs >= 0) check_val("frame_period", meas_cyc - last_fs, HT * VT * CD);
            last_fs = meas_cyc;
        end
        if (p_tick_a && video_on_a)   von_cnt++;
        if (p_tick_a && video_on_d_a) vod_cnt++;
    endtask

    task automatic step_a(input bit r, input bit e);
        @(negedge clk);
        reset_a = r;
        en_a    = e;
        #1;
        if (known_a) check_a();
        if (meas_on) measure_a();
        @(posedge clk);
        if (r) begin
            n_a = 0;
            known_a = 1;
        end else if (e) begin
            n_a++;
        end
    endtask

    task automatic check_b();
        int x, y;
        bit pt;
        x  = n_b % BHT;
        y  = (n_b / BHT) % VT;
        pt = !reset_b;
        check_val("b_p_tick", p_tick_b, pt);
        check_val("b_pixel_x", pixel_x_b, x);
        check_val("b_pixel_y", pixel_y_b, y);
        check_val("b_hsync", hsync_b, sync_level(x, BHA, BHF, BHS));
        check_val("b_vsync", vsync_b, sync_level(y, VA, VF, VS));
        check_val("b_video_on", video_on_b, (x < BHA) && (y < VA));
        check_val("b_video_on_d", video_on_d_b, (x < BHA) && (y < VA));
        check_val("b_line_start", line_start_b, pt && (x == 0));
        check_val("b_frame_start", frame_start_b, pt && (x == 0) && (y == 0));
    endtask

    task automatic step_b(input bit r);
        @(negedge clk);
        reset_b = r;
        en_b    = 1'b1;
        #1;
        if (known_b) check_b();
        cyc_b++;
        if (!r && frame_start_b) begin
            if (last_fs_b >= 0) check_val("b_frame_period", cyc_b - last_fs_b, BHT * VT);
            last_fs_b = cyc_b;
        end
        @(posedge clk);
        if (r) begin
            n_b = 0;
            known_b = 1;
        end else begin
            n_b++;
        end
    endtask

    initial begin
        int guard;

        $display("txn 1: reset, then two free-running frames in the small mode");
        repeat (3) step_a(1'b1, 1'b0);
        meas_on = 1;
        repeat (2 * HT * VT * CD) step_a(1'b0, 1'b1);
        meas_on = 0;
        check_val("first_tick_latency", first_tick, CD);
        check_val("video_on_ticks_2frames", von_cnt, 2 * HA * VA);
        check_val("video_on_d_ticks_2frames", vod_cnt, 2 * HA * VA);

        $display("txn 2: enable held low for 9 clks at x=5 y=2");
        step_a(1'b1, 1'b1);
        guard = 0;
        while (n_a != (2 * HT + 5) * CD && guard < 1000) begin
            step_a(1'b0, 1'b1);
            guard++;
        end
        #2;
        check_val("freeze_at_x", pixel_x_a, 5);
        check_val("freeze_at_y", pixel_y_a, 2);
        repeat (9) step_a(1'b0, 1'b0);
        step_a(1'b0, 1'b1);
        step_a(1'b0, 1'b1);
        #2;
        check_val("freeze_resume_x", pixel_x_a, 6);
        check_val("freeze_resume_y", pixel_y_a, 2);

        $display("txn 3: reset asserted at x=11 y=5");
        step_a(1'b1, 1'b1);
        guard = 0;
        while (n_a != (5 * HT + 11) * CD && guard < 1000) begin
            step_a(1'b0, 1'b1);
            guard++;
        end
        #2;
        check_val("midframe_at_x", pixel_x_a, 11);
        check_val("midframe_at_y", pixel_y_a, 5);
        step_a(1'b1, 1'b1);
        #2;
        check_val("rst_pixel_x", pixel_x_a, 0);
        check_val("rst_pixel_y", pixel_y_a, 0);
        check_val("rst_hsync", hsync_a, 1);
        check_val("rst_vsync", vsync_a, 1);
        check_val("rst_video_on_d", video_on_d_a, 0);
        check_val("rst_p_tick", p_tick_a, 0);

        $display("txn 4: 3000 clks of random enable and occasional reset");
        for (int i = 0; i < 3000; i++) begin
            step_a($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end

        $display("txn 5: 640-wide mode, CLK_DIV 1, PIPE 0, over one frame plus margin");
        repeat (2) step_b(1'b1);
        repeat (BHT * VT + 100) step_b(1'b0);
        check_val("b_frame_seen", last_fs_b > 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
